// File: rtl/key_pkg.sv
// Shared definitions for the key event scheduler: default timing, the event
// record and the round-robin search used by the arbiter.
package key_pkg;

   localparam int DEFAULT_TICK_BITS    = 19;
   localparam int DEFAULT_STABLE_TICKS = 3;
   localparam int MAX_KEYS             = 8;

   typedef struct packed {
      logic [2:0] key;
      logic       rel;
   } key_event_t;

   // First set bit of req at or after ptr, wrapping modulo n; -1 when none.
   function automatic int rr_first(input logic [MAX_KEYS-1:0] req,
                                   input int ptr,
                                   input int n);
      int hit;
      int idx;
      hit = -1;
      for (int i = MAX_KEYS - 1; i >= 0; i--) begin
         if (i < n) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (req[idx[2:0]]) hit = idx;
         end
      end
      return hit;
   endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Valid/ready event stream between the key scheduler and its consumer.
interface key_event_scheduler_if #(
   parameter int KEY_W = 2
);
   logic             ev_valid;
   logic [KEY_W-1:0] ev_key;
   logic             ev_release;
   logic             ev_ready;
   logic             ev_overrun;

   modport master (output ev_valid, ev_key, ev_release, ev_overrun,
                   input  ev_ready);
   modport slave  (input  ev_valid, ev_key, ev_release, ev_overrun,
                   output ev_ready);
endinterface

// File: rtl/key_debounce_lane.sv
// One key: two-flop synchronizer, tick-based stability counter and debounced
// level, with single-cycle rise/fall pulses on each accepted change.
module key_debounce_lane
   import key_pkg::*;
#(
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   input  logic tick,
   output logic key_level,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_reg;
   logic [2:0] stab_cnt_reg;
   logic       level_reg;
   logic       sync_key;
   logic       accept;

   assign sync_key = sync_reg[1];
   assign accept   = (sync_key != level_reg) && tick &&
                     (stab_cnt_reg == 3'(STABLE_TICKS - 1));

   // Any return to the current level clears qualification, even between ticks.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_reg     <= '0;
         stab_cnt_reg <= '0;
         level_reg    <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[0], key_raw};
         if (sync_key == level_reg) begin
            stab_cnt_reg <= '0;
         end else if (accept) begin
            level_reg    <= sync_key;
            stab_cnt_reg <= '0;
         end else if (tick) begin
            stab_cnt_reg <= stab_cnt_reg + 3'd1;
         end
      end
   end

   assign key_level = level_reg;
   assign rise      = accept && sync_key;
   assign fall      = accept && !sync_key;

endmodule

// File: rtl/key_event_scheduler.sv
// Debounces NUM_KEYS buttons on a shared tick and round-robins press events
// (and release events when KEY_RELEASE_EV_EN is defined) onto one stream.
module key_event_scheduler
   import key_pkg::*;
#(
   parameter int NUM_KEYS     = 4,
   parameter int TICK_BITS    = DEFAULT_TICK_BITS,
   parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NUM_KEYS-1:0]   key_raw,
   output logic [NUM_KEYS-1:0]   key_level,
   key_event_scheduler_if.master ev,
   output logic                  tick
);

   localparam int KW = $clog2(NUM_KEYS);

   logic [TICK_BITS-1:0] count_reg;
   logic [NUM_KEYS-1:0]  rise;
   logic [NUM_KEYS-1:0]  fall;
   logic [NUM_KEYS-1:0]  press_pend_reg;
   logic [NUM_KEYS-1:0]  press_next;
   logic [NUM_KEYS-1:0]  rel_pend;
   logic [KW-1:0]        rr_ptr_reg;
   logic                 ev_valid_reg;
   logic [KW-1:0]        ev_key_reg;
   logic                 ev_release_reg;
   logic                 overrun_reg;
   logic                 overrun_next;
   logic                 load;
   logic                 grant_hit;
   logic                 grant_rel;
   int                   grant_idx;

   assign tick = &count_reg;

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_lane
         key_debounce_lane #(.STABLE_TICKS(STABLE_TICKS)) u_lane (
            .clock     (clock),
            .reset     (reset),
            .key_raw   (key_raw[gi]),
            .tick      (tick),
            .key_level (key_level[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
         );
      end
   endgenerate

`ifdef KEY_RELEASE_EV_EN
   logic [NUM_KEYS-1:0] rel_pend_reg;
   logic [NUM_KEYS-1:0] rel_next;
   assign rel_pend = rel_pend_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) rel_pend_reg <= '0;
      else       rel_pend_reg <= rel_next;
   end
`else
   logic unused_fall;
   assign rel_pend    = '0;
   assign unused_fall = ^fall;
`endif

   // Grant clears its flag before new raises are applied, so a same-cycle
   // grant and raise on one key leaves the flag set without an overrun.
   always_comb begin
      load       = !ev_valid_reg || ev.ev_ready;
      grant_idx  = rr_first(MAX_KEYS'(press_pend_reg | rel_pend),
                            int'(rr_ptr_reg), NUM_KEYS);
      grant_hit  = load && (grant_idx >= 0);
      grant_rel  = 1'b0;
      press_next = press_pend_reg;
      overrun_next = 1'b0;
`ifdef KEY_RELEASE_EV_EN
      rel_next   = rel_pend_reg;
`endif
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (grant_hit && grant_idx == k) begin
            if (press_pend_reg[k]) begin
               press_next[k] = 1'b0;
            end else begin
               grant_rel = 1'b1;
`ifdef KEY_RELEASE_EV_EN
               rel_next[k] = 1'b0;
`endif
            end
         end
         if (rise[k]) begin
            if (press_next[k]) overrun_next = 1'b1;
            press_next[k] = 1'b1;
         end
`ifdef KEY_RELEASE_EV_EN
         if (fall[k]) begin
            if (rel_next[k]) overrun_next = 1'b1;
            rel_next[k] = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_reg      <= '0;
         press_pend_reg <= '0;
         rr_ptr_reg     <= '0;
         ev_valid_reg   <= 1'b0;
         ev_key_reg     <= '0;
         ev_release_reg <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         count_reg      <= count_reg + TICK_BITS'(1);
         press_pend_reg <= press_next;
         overrun_reg    <= overrun_next;
         if (load) begin
            ev_valid_reg <= grant_hit;
            if (grant_hit) begin
               ev_key_reg     <= KW'(grant_idx);
               ev_release_reg <= grant_rel;
               rr_ptr_reg     <= (grant_idx == NUM_KEYS - 1) ? '0 : KW'(grant_idx + 1);
            end
         end
      end
   end

   assign ev.ev_valid   = ev_valid_reg;
   assign ev.ev_key     = ev_key_reg;
   assign ev.ev_release = ev_release_reg;
   assign ev.ev_overrun = overrun_reg;

endmodule
